rf_wb_arbiter: RTL

- Write-back arbiter and scoreboard for the 16 x 16-bit register file.
- Three producers compete for the single register-file write port: ALU (req 0), load unit (req 1) and mul/div unit (req 2). Arbitration is round-robin.
- Drives the per-register enable lines and the shared write data from a one-cycle output stage.
- Tracks which registers have a write pending, and flags read-after-write hazards to the issue stage.

---
 rtl/rf_wb_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and scoreboard for the register file.
// Three producers (ALU=0, load=1, mul/div=2) share one write port under
// round-robin arbitration. Writes leave through a one-cycle output stage.
// A pending-write bitmap drives the read-after-write hazard flags for issue.
module rf_wb_arbiter #(
    parameter int DW   = 16,
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [2:0]        req_valid,
    input  logic [3*AW-1:0]   req_dest,
    input  logic [3*DW-1:0]   req_data,
    output logic [2:0]        req_ready,
    output logic [NREG-1:0]   wr_en,
    output logic [DW-1:0]     wr_data,
    output logic [AW-1:0]     wr_dest,
    output logic [1:0]        wr_src,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_dest,
    input  logic [AW-1:0]     rd_a,
    input  logic [AW-1:0]     rd_b,
    output logic              hz_a,
    output logic              hz_b,
    output logic [NREG-1:0]   pend,
    output logic              wb_orphan
);

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    logic [1:0]      rr_q, rr_d;
    logic [NREG-1:0] wr_en_q, wr_en_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [AW-1:0]   wr_dest_q, wr_dest_d;
    logic [1:0]      wr_src_q, wr_src_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic            orphan_q, orphan_d;

    logic [1:0]      acc_idx;
    logic            accept;
    logic [2:0]      sum3;
    logic [1:0]      cand;
    logic [AW-1:0]   sel_dest;
    logic [NREG-1:0] iss_mask;

    // Round-robin grant: first valid producer starting from rr, wrapping mod 3.
    always_comb begin
        req_ready = '0;
        acc_idx   = '0;
        accept    = 1'b0;
        sum3      = '0;
        cand      = '0;
        if (!rst && !hold) begin
            for (int j = 0; j < 3; j++) begin
                sum3 = {1'b0, rr_q} + 3'(j);
                if (sum3 >= 3'd3) begin
                    sum3 = sum3 - 3'd3;
                end
                cand = sum3[1:0];
                if (!accept && req_valid[cand]) begin
                    req_ready[cand] = 1'b1;
                    acc_idx         = cand;
                    accept          = 1'b1;
                end
            end
        end
    end

    // Next state: pointer advance, output stage load, scoreboard update.
    always_comb begin
        rr_d      = rr_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        wr_dest_d = wr_dest_q;
        wr_src_d  = wr_src_q;
        sel_dest  = req_dest[int'(acc_idx)*AW +: AW];
        if (accept) begin
            rr_d      = (acc_idx == 2'd2) ? 2'd0 : acc_idx + 2'd1;
            wr_en_d   = ONE << sel_dest;
            wr_data_d = req_data[int'(acc_idx)*DW +: DW];
            wr_dest_d = sel_dest;
            wr_src_d  = acc_idx;
        end
        iss_mask = iss_valid ? (ONE << iss_dest) : '0;
        // A new allocation wins over a write completing in the same cycle.
        pend_d   = (pend_q & ~wr_en_q) | iss_mask;
        orphan_d = |(wr_en_q & ~pend_q);
    end

    // State registers; reset drops any write sitting in the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            wr_dest_q <= '0;
            wr_src_q  <= '0;
            pend_q    <= '0;
            orphan_q  <= 1'b0;
        end else begin
            rr_q      <= rr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_dest_q <= wr_dest_d;
            wr_src_q  <= wr_src_d;
            pend_q    <= pend_d;
            orphan_q  <= orphan_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign wr_dest   = wr_dest_q;
    assign wr_src    = wr_src_q;
    assign pend      = pend_q;
    assign wb_orphan = orphan_q;

    // Register file bypasses, so a write completing this cycle is not a hazard.
    assign hz_a = pend_q[rd_a] & ~wr_en_q[rd_a];
    assign hz_b = pend_q[rd_b] & ~wr_en_q[rd_b];

endmodule
